// File: rtl/parity_check_serial.sv
// ---------------------------------------------------------------------------
// parity_check_serial
//
// Serial-input parity checker. A frame is DATA_W data bits (MSB first)
// followed by one parity bit, each qualified by bit_valid. The data word is
// deserialised and its parity is checked in even or odd mode. The mode is
// latched when the frame starts. A saturating error counter and a sticky
// error flag give status readback.
//
// Parameters
//   DATA_W     data bits per frame (1..64)
//   CNT_W      error counter width (1..32)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   odd_mode   0 = even parity, 1 = odd parity; sampled when start is taken
//   start      begins a frame; honoured only while idle
//   bit_in     serial data/parity bit
//   bit_valid  bit_in is valid this cycle
//   clr_cnt    clears err_cnt and err_sticky
//   busy       frame in progress
//   data_out   last deserialised data word (held until the next done)
//   done       one-cycle pulse when a frame completes
//   pc         parity error of the last frame (1 = error)
//   err_cnt    saturating count of frames with a parity error
//   err_sticky set by any parity error; cleared by clr_cnt or rst
// ---------------------------------------------------------------------------
module parity_check_serial #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              clr_cnt,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              pc,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky
);

  // The bit counter can reach DATA_W, so it is sized for that value.
  localparam int               BC_W     = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_acc;
  logic [BC_W-1:0]     r_bit_cnt;
  logic                r_mode;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_done;
  logic                r_pc;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                r_sticky;

  logic                w_start_take;
  logic                w_data_take;
  logic                w_data_last;
  logic                w_par_take;
  logic                w_err;
  logic                w_err_frame;

  assign w_start_take = (r_state == S_IDLE) && start;
  assign w_data_take  = (r_state == S_DATA) && bit_valid;
  assign w_data_last  = w_data_take && (r_bit_cnt == LAST_BIT);
  assign w_par_take   = (r_state == S_PAR) && bit_valid;
  // The accumulator holds the XOR of the data bits. XORing in the parity bit
  // and the mode gives 1 exactly when the frame's ones count is wrong.
  assign w_err        = r_acc ^ bit_in ^ r_mode;
  assign w_err_frame  = w_par_take && w_err;

  // NOTE: every signal written in always_comb gets a default first, so no
  //       path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start)       w_state_nxt = S_DATA;
      S_DATA:  if (w_data_last) w_state_nxt = S_PAR;
      S_PAR:   if (bit_valid)   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  //       read the pre-edge values, so the order of the statements does not
  //       matter.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the datapath registers are few and are not a memory, so all of
  //       them are reset. This gives defined outputs straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_acc      <= 1'b0;
      r_bit_cnt  <= '0;
      r_mode     <= 1'b0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_pc       <= 1'b0;
      r_err_cnt  <= '0;
      r_sticky   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_start_take) begin
        r_mode    <= odd_mode;
        r_acc     <= 1'b0;
        r_bit_cnt <= '0;
      end

      if (w_data_take) begin
        // New bit enters at the LSB. Earlier bits move toward the MSB, which
        // puts the first (MSB-first) bit at the top after DATA_W shifts.
        r_shift   <= (r_shift << 1) | DATA_W'(bit_in);
        r_acc     <= r_acc ^ bit_in;
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end

      if (w_par_take) begin
        r_done     <= 1'b1;
        r_data_out <= r_shift;
        r_pc       <= w_err;
      end

      // When a clear meets an error completion, the new error is kept.
      if (clr_cnt) begin
        r_err_cnt <= w_err_frame ? CNT_W'(1) : '0;
        r_sticky  <= w_err_frame;
      end else if (w_err_frame) begin
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
        r_sticky <= 1'b1;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign data_out   = r_data_out;
  assign done       = r_done;
  assign pc         = r_pc;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_sticky;

endmodule

// File: doc/parity_check_serial.md
Name: parity_check_serial

Overview:
- Serial-input parity checker, the parametrised successor to the team's fixed 3-bit combinational even-parity checker.
- Receives a framed serial stream: DATA_W data bits, MSB first, then one parity bit.
- Deserialises the data word and checks parity in even or odd mode, selected per frame.
- Keeps a saturating error counter and a sticky error flag for status readback; sits between a serial link receiver and the word-level datapath.

Parameters:
- DATA_W, 3, data bits per frame; legal values 1..64.
- CNT_W, 8, width of the error counter; legal values 1..32.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled only on the cycle start is accepted.
- start  input  1  begins a frame; honoured only in IDLE.
- bit_in  input  1  serial data/parity bit; qualified by bit_valid.
- bit_valid  input  1  bit_in is valid this cycle.
- clr_cnt  input  1  clears err_cnt and err_sticky.
- busy  output  1  high while a frame is in progress (state != IDLE).
- data_out  output  DATA_W  last deserialised data word.
- done  output  1  one-cycle pulse when a frame completes.
- pc  output  1  parity error of the last frame: 1 = error.
- err_cnt  output  CNT_W  count of frames with a parity error; saturating.
- err_sticky  output  1  set by any parity error; cleared only by clr_cnt or rst.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE.
  - busy, done, pc, err_sticky = 0; data_out = 0; err_cnt = 0.
  - Internal shift register, parity accumulator, bit counter and latched mode = 0.
  - Reset wins over every other input and aborts any frame in progress; no done is produced for the aborted frame.
- FSM states: IDLE, DATA, PAR.
- IDLE:
  - If start=1: latch odd_mode, clear the accumulator and bit counter, go to DATA.
  - bit_valid and bit_in are ignored on the start cycle and in IDLE generally.
- DATA:
  - Each cycle with bit_valid=1 shifts bit_in into the LSB of the shift register (earlier bits move toward the MSB), XORs bit_in into the accumulator and increments the bit counter.
  - When the DATA_W-th bit is accepted, go to PAR.
  - Cycles with bit_valid=0 hold all state; gaps of any length are legal.
- PAR, on bit_valid=1:
  - Compute err = acc ^ bit_in ^ mode. Even mode flags an error when the total count of ones over data plus parity is odd; odd mode flags an error when that total is even.
  - Next edge: done=1 for exactly one cycle; data_out = shift register; pc = err; go to IDLE.
- Output holding: data_out and pc hold their values until the next done.
- Latency: done and pc appear 1 cycle after the parity bit is accepted; a frame takes at least DATA_W+2 cycles from start.
- Back-to-back frames: start may be asserted in the cycle done is high, since the state is already IDLE.
- start while busy=1: ignored and has no effect.
- Counter:
  - On each error frame (at the done edge), err_cnt increments, saturating at 2^CNT_W-1, and err_sticky is set to 1.
- clr_cnt:
  - Sets err_cnt = 0 and err_sticky = 0 at the next edge.
  - If clr_cnt coincides with an error-frame completion, the result is err_cnt = 1 and err_sticky = 1 (the new error is not lost).
- DATA_W = 1: DATA takes a single bit, then goes to PAR.
- odd_mode changes mid-frame have no effect on the current frame.

Test Plan:
- DATA_W=3, even mode: start, bits 1,0,1, parity 0 -> done pulse 1 cycle after the parity bit; data_out=3'b101, pc=0, err_cnt=0, err_sticky=0.
- Same frame with parity 1 -> pc=1, err_cnt=1, err_sticky=1. Then odd mode: bits 1,1,1, parity 0 -> pc=0; bits 1,1,1, parity 1 -> pc=1, err_cnt=2.
- bit_valid gaps: 0-3 idle cycles between bits, plus start pulsed during DATA -> results identical to the gap-free frame; the mid-frame start is ignored.
- CNT_W=2: five error frames -> err_cnt goes 1,2,3,3,3. Then clr_cnt on the same cycle as a sixth error's done edge -> err_cnt=1, err_sticky=1.
- rst asserted after 2 data bits -> next cycle busy=0, all outputs 0, no done pulse. A following full frame 0,1,1 with parity 0 (even) -> data_out=3'b011, pc=0.
- Back-to-back: start asserted in the done cycle, next frame 1,1,0 with parity 1, even mode -> second done shows data_out=3'b110, pc=1.
